// File: rtl/result_drain_control_if.sv
// Output-SRAM read port and result stream bundled for the result drain block.
// master = drain controller side, slave = SRAM / downstream side.
interface result_drain_control_if #(
    parameter int WORD_W = 256,
    parameter int AW     = 6
);
    logic              sram_read_enable;
    logic [AW-1:0]     sram_raddr;
    logic [WORD_W-1:0] sram_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [AW-1:0]     out_index;
    logic              out_last;

    modport master (
        output sram_read_enable, sram_raddr,
        input  sram_rdata,
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  sram_read_enable, sram_raddr,
        output sram_rdata,
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/result_drain_control.sv
// Drains the 64 result rows from the output SRAM after tpu_done and streams them
// out one row per beat, using a small credit-managed FIFO to absorb read latency.
module result_drain_control #(
    parameter int ARRAY_SIZE   = 16,
    parameter int WORD_W       = 256,
    parameter int ROWS_PER_SET = 32,
    parameter int NUM_SETS     = 2,
    parameter int FIFO_DEPTH   = 3
) (
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    tpu_done,
    result_drain_control_if.master  bus,
    output logic                    drain_busy,
    output logic                    drain_done
);
    // ARRAY_SIZE only documents the array geometry; it never affects addressing.
    localparam int AW = $clog2(ROWS_PER_SET * NUM_SETS) + (0 * ARRAY_SIZE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS_PER_SET * NUM_SETS - 1);
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [AW-1:0]     cnt_r, cnt_s;
    logic              ren_r, ren_s;
    logic              inflight_r;
    logic [AW-1:0]     inflight_addr_r;
    logic [WORD_W-1:0] data_mem_r [FIFO_DEPTH];
    logic [AW-1:0]     idx_mem_r  [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     occ_r, occ_s;
    logic [CW:0]       credit_s;
    logic              push_s, pop_s, last_pop_s;
    logic              busy_s, done_s;
    logic              drain_busy_r, drain_done_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Next-state, counter and read-credit decode.
    always_comb begin
        push_s     = inflight_r;
        pop_s      = (occ_r != {CW{1'b0}}) && bus.out_ready;
        last_pop_s = pop_s && (idx_mem_r[rd_ptr_r] == LAST_ADDR);
        case ({push_s, pop_s})
            2'b10:   occ_s = occ_r + CW'(1);
            2'b01:   occ_s = occ_r - CW'(1);
            default: occ_s = occ_r;
        endcase

        state_s = state_r;
        cnt_s   = cnt_r;
        busy_s  = drain_busy_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (tpu_done) begin
                    state_s = READ;
                    cnt_s   = {AW{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (ren_r) begin
                    if (cnt_r == LAST_ADDR) begin
                        state_s = FLUSH;
                    end else begin
                        cnt_s = cnt_r + AW'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            FLUSH: begin
                if (last_pop_s) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = FLUSH;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase

        // Next cycle's buffered entries plus the read this cycle puts in flight.
        credit_s = {1'b0, occ_s} + {{CW{1'b0}}, ren_r};
        if ((state_s == READ) && (credit_s < DEPTH_C)) begin
            ren_s = 1'b1;
        end else begin
            ren_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Read strobe, address counter, in-flight tracking and status outputs.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            cnt_r           <= {AW{1'b0}};
            ren_r           <= 1'b0;
            inflight_r      <= 1'b0;
            inflight_addr_r <= {AW{1'b0}};
            drain_busy_r    <= 1'b0;
            drain_done_r    <= 1'b0;
        end else begin
            cnt_r           <= cnt_s;
            ren_r           <= ren_s;
            inflight_r      <= ren_r;
            inflight_addr_r <= cnt_r;
            drain_busy_r    <= busy_s;
            drain_done_r    <= done_s;
        end
    end

    // Output FIFO storage and pointers.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= {WORD_W{1'b0}};
                idx_mem_r[i]  <= {AW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            occ_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= bus.sram_rdata;
                idx_mem_r[wr_ptr_r]  <= inflight_addr_r;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            occ_r <= occ_s;
        end
    end

    assign bus.sram_read_enable = ren_r;
    assign bus.sram_raddr       = cnt_r;
    assign bus.out_valid        = (occ_r != {CW{1'b0}});
    assign bus.out_data         = data_mem_r[rd_ptr_r];
    assign bus.out_index        = idx_mem_r[rd_ptr_r];
    assign bus.out_last         = (occ_r != {CW{1'b0}}) && (idx_mem_r[rd_ptr_r] == LAST_ADDR);
    assign drain_busy           = drain_busy_r;
    assign drain_done           = drain_done_r;
endmodule

// File: tb/tb_result_drain_control.sv
// Directed-plus-random bench for result_drain_control with a beat-level reference
// model: rows 0..63 in order, data from the SRAM image, at most 3 rows outstanding.
module tb_result_drain_control;
    localparam int WORD_W = 256;

    logic clk = 1'b0;
    logic srstn;
    logic tpu_done;
    logic drain_busy;
    logic drain_done;

    always #5 clk = ~clk;

    result_drain_control_if #(.WORD_W(WORD_W), .AW(6)) bus ();

    result_drain_control #(.WORD_W(WORD_W)) dut (
        .clk        (clk),
        .srstn      (srstn),
        .tpu_done   (tpu_done),
        .bus        (bus),
        .drain_busy (drain_busy),
        .drain_done (drain_done)
    );

    // SRAM image with one-cycle read latency
    logic [WORD_W-1:0] mem [64];
    logic [WORD_W-1:0] rdata_q;
    always @(posedge clk) begin
        if (bus.sram_read_enable) rdata_q <= mem[bus.sram_raddr];
    end
    assign bus.sram_rdata = rdata_q;

    int n_vec = 0;
    int n_err = 0;
    bit active = 1'b0;
    bit done_pending = 1'b0;
    bit stall_prev = 1'b0;
    bit seen_valid = 1'b0;
    bit timing_chk = 1'b0;
    int exp_idx = 0;
    int issued = 0;
    int accepted = 0;
    int tick_no = 0;
    int start_tick = 0;
    logic [WORD_W-1:0] prev_data;

    task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return ((i % 4) == 0) || ((i % 4) == 3);
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    task automatic fill_mem(input bit pattern);
        logic [31:0] w;
        for (int a = 0; a < 64; a++) begin
            for (int j = 0; j < 8; j++) begin
                w = pattern ? 32'(a) : $urandom;
                mem[a][j*32 +: 32] = w;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, check, then advance the model.
    task automatic tick(input logic rdy, input logic tpu);
        bit acc;
        bit start;
        @(negedge clk);
        tick_no++;
        bus.out_ready = rdy;
        tpu_done      = tpu;
        check("drain_busy", drain_busy, active);
        check("drain_done", drain_done, done_pending);
        done_pending = 1'b0;
        if (!active) begin
            check("valid_idle", bus.out_valid, 1'b0);
            check("read_idle", bus.sram_read_enable, 1'b0);
        end
        if (stall_prev) check("valid_held", bus.out_valid, 1'b1);
        if (bus.out_valid && active) begin
            if (!seen_valid) begin
                seen_valid = 1'b1;
                if (timing_chk) check("first_valid_lat", tick_no - start_tick, 3);
            end
            check("out_index", bus.out_index, exp_idx);
            check("out_data", bus.out_data, mem[exp_idx]);
            check("out_last", bus.out_last, exp_idx == 63);
            if (stall_prev) check("stall_stable", bus.out_data, prev_data);
        end
        stall_prev = bus.out_valid && !rdy && active;
        prev_data  = bus.out_data;
        if (bus.sram_read_enable && active) begin
            check("read_addr", bus.sram_raddr, issued);
            check("read_bound", issued < 64, 1'b1);
            check("credit", (issued - accepted) < 3, 1'b1);
            issued++;
        end
        acc   = bus.out_valid && rdy && active;
        start = tpu && !active;
        if (acc) begin
            if (exp_idx == 63) begin
                active       = 1'b0;
                done_pending = 1'b1;
                if (timing_chk) check("last_accept_edge", tick_no - start_tick, 66);
            end
            exp_idx++;
            accepted++;
        end
        if (start) begin
            active     = 1'b1;
            exp_idx    = 0;
            issued     = 0;
            accepted   = 0;
            start_tick = tick_no;
            seen_valid = 1'b0;
            stall_prev = 1'b0;
        end
    endtask

    task automatic drain(input int mode, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!active) break;
            tick(pick_ready(mode, i), 1'b0);
        end
        check("drain_timeout", active, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_read_enable", bus.sram_read_enable, 1'b0);
        check("rst_raddr", bus.sram_raddr, 6'd0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, {WORD_W{1'b0}});
        check("rst_out_index", bus.out_index, 6'd0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_drain_busy", drain_busy, 1'b0);
        check("rst_drain_done", drain_done, 1'b0);
    endtask

    initial begin
        srstn         = 1'b0;
        tpu_done      = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        srstn = 1'b1;

        // 1: full-rate drain with exact latency
        fill_mem(1'b1);
        timing_chk = 1'b1;
        tick(1'b1, 1'b1);
        drain(0, 200);
        repeat (2) tick(1'b1, 1'b0);
        timing_chk = 1'b0;

        // 2: ready pattern 1,0,0,1
        fill_mem(1'b0);
        tick(1'b1, 1'b1);
        drain(1, 400);
        repeat (2) tick(1'b1, 1'b0);

        // 3: long stall right after start
        fill_mem(1'b0);
        tick(1'b0, 1'b1);
        repeat (20) tick(1'b0, 1'b0);
        check("reads_while_stalled", issued, 3);
        check("read_enable_stalled", bus.sram_read_enable, 1'b0);
        drain(0, 200);
        repeat (2) tick(1'b1, 1'b0);

        // 4: second tpu_done mid-drain is ignored
        fill_mem(1'b0);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (exp_idx >= 10) break;
            tick(pick_ready(2, i), 1'b0);
        end
        check("reach_beat10", exp_idx, 10);
        tick(pick_ready(2, 0), 1'b1);
        drain(2, 600);
        repeat (3) tick(1'b1, 1'b0);

        // 5: asynchronous reset at beat 30, then a fresh drain
        fill_mem(1'b0);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (exp_idx >= 30) break;
            tick(1'b1, 1'b0);
        end
        check("reach_beat30", exp_idx, 30);
        #2 srstn = 1'b0;
        #1;
        check_reset_outputs();
        active       = 1'b0;
        done_pending = 1'b0;
        stall_prev   = 1'b0;
        @(negedge clk);
        srstn = 1'b1;
        repeat (3) tick(1'b1, 1'b0);
        fill_mem(1'b0);
        tick(1'b1, 1'b1);
        drain(2, 600);

        // 6: tpu_done coincident with drain_done restarts immediately
        tick(1'b1, 1'b1);
        check("restart_active", active, 1'b1);
        drain(0, 200);
        repeat (2) tick(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
